load_store_unit: RTL
====================

# load_store_unit

Core-side initiator for the byte-addressable data memory. Accepts one load or store per request from the execute stage and issues the matching memory control (write enable, read type, addresses, store data). Aligned accesses complete as a single memory access. With ALLOW_MISALIGNED=1, misaligned halfword/word accesses are split into sequential byte accesses; otherwise they fault. Returns load data, sign- or zero-extended, plus a fault flag.

## Interface
- MEMORY_SIZE, 1024: bytes of data memory; accesses touching any byte at or beyond this address fault.
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses into byte accesses; 0 = fault them.
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous active-high reset. One clock; reset synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU idle; request accepted when req_valid && req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (loads 000/001/010/100/101; stores 000/001/010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  illegal funct3, out-of-range, or misaligned with ALLOW_MISALIGNED=0.
- mem_WR_Addr / mem_RD_Addr  out  32  memory byte address (both driven with the same value).
- mem_Din  out  32  memory store data.
- mem_WE  out  2  00 none, 01 byte, 10 half, 11 word.
- mem_RD_Type  out  3  {unsigned, size[1:0]}.
- mem_Dout  in  32  combinational read data.

## Operation
- States: IDLE, ACCESS, BYTE, RESP. req_ready = (state==IDLE).
- On accept, register store flag, funct3, address, wdata; clear byte index k and assembly buffer.
- Size: funct3[1:0] gives 1/2/4 bytes. Illegal funct3 (loads 011/110/111; stores anything except 000/001/010) -> RESP with fault, no memory access.
- Range check uses 33-bit arithmetic, so no wrap-around: addr + size > MEMORY_SIZE -> fault, no access.
- Aligned (halfword addr[0]==0, word addr[1:0]==00, or byte): go to ACCESS. Drive address=addr and mem_RD_Type=funct3. For a store, drive mem_WE per size and mem_Din=wdata. For a load, capture mem_Dout into resp data. Then go to RESP.
- Misaligned with ALLOW_MISALIGNED=0: fault, no access.
- Misaligned with ALLOW_MISALIGNED=1: BYTE state for k=0..size-1. Drive address=addr+k and mem_RD_Type=100.
  - Store: mem_WE=01, mem_Din[7:0]=wdata[8k+7:8k].
  - Load: buffer byte k = mem_Dout[7:0].
  - After the last byte, extend the buffer per funct3 (bit 2 = zero-extend) and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- mem_WE is 00 in every state except ACCESS/BYTE of a legal store. Memory address/data outputs hold their last value otherwise.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_WE=00, addresses=0, mem_Din=0, mem_RD_Type=010.
- Accept at edge N. Aligned access occurs in cycle N+1; resp_valid in cycle N+2 (latency 2).
- Misaligned halfword: bytes in cycles N+1..N+2, resp in N+3. Misaligned word: bytes in N+1..N+4, resp in N+5.
- Fault: resp_valid in cycle N+1, with no cycle in which mem_WE≠00.
- Next request can be accepted in the cycle after resp_valid (req_ready=0 from N+1 through RESP).
- Store write commits at the rising edge ending the ACCESS/BYTE cycle. Load data is sampled at that same edge.
- Rst mid-operation: return to IDLE the next edge with mem_WE=00. Bytes already written by a split store remain written, and no response is issued.
- Rst asserted together with req_valid: the request is dropped.

## Test plan
- Aligned SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> one cycle with mem_WE=11; load resp_rdata=0xDEADBEEF, fault=0, latency 2.
- LB/LBU addr=0x13 over that word -> 0xFFFFFFDE / 0x000000DE; LH/LHU addr=0x12 -> 0xFFFFDEAD / 0x0000DEAD.
- ALLOW_MISALIGNED=1, SW addr=0x21, wdata=0x11223344 -> four byte writes at 0x21..0x24 (44,33,22,11); LW 0x21 -> 0x11223344, resp in N+5; LH 0x23 -> sign-extended 0x00001122.
- ALLOW_MISALIGNED=0, LW addr=0x22 -> resp_fault=1, rdata=0, latency 1, mem_WE never asserted.
- Range/illegal: LW addr=0x3FE (MEMORY_SIZE=1024) -> fault; load funct3=011 -> fault; SW addr=0xFFFFFFFE -> fault (no wrap).
- Rst asserted during the 3rd byte of a split SW -> idle next cycle, no resp_valid, only bytes 0–1 modified; next request accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
// ---------------
// Core-side initiator for a byte-addressable data memory. Takes one load or
// store per request, drives the memory control for it and returns the
// (extended) load data together with a fault flag.
//
// Aligned accesses use a single memory cycle. Misaligned halfword/word
// accesses are either split into sequential byte accesses
// (ALLOW_MISALIGNED=1) or faulted (ALLOW_MISALIGNED=0).
//
// Ports
//   Clk, Rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_store            1 = store, 0 = load
//   req_funct3           RV32I load/store funct3
//   req_addr, req_wdata  byte address, LSB-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and faults)
//   resp_fault           illegal funct3, out of range, or disallowed misalign
//   mem_WR_Addr/RD_Addr  memory byte address (same value on both)
//   mem_Din              memory store data
//   mem_WE               00 none, 01 byte, 10 half, 11 word
//   mem_RD_Type          {unsigned, size[1:0]}
//   mem_Dout             combinational memory read data
module load_store_unit #(
    parameter int MEMORY_SIZE      = 1024,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_WR_Addr,
    output logic [31:0] mem_RD_Addr,
    output logic [31:0] mem_Din,
    output logic [1:0]  mem_WE,
    output logic [2:0]  mem_RD_Type,
    input  logic [31:0] mem_Dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_BYTE   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  k_q;
    logic [31:0] buf_q;
    logic [31:0] mem_addr;
    logic [1:0]  we_q;

    // request decode, evaluated on the request inputs in the accept cycle
    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_illegal;
    logic        req_oor;
    logic        req_misal;
    logic        req_fault;

    always_comb begin
        req_size = 3'd1;
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd1;
        endcase
        // loads: 011/110/111 illegal; stores: only 000/001/010 legal
        if (req_store)
            req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        req_end   = {1'b0, req_addr} + {30'd0, req_size};
        req_oor   = req_end > 33'(MEMORY_SIZE);
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_fault = req_illegal || req_oor || (req_misal && (ALLOW_MISALIGNED == 0));
    end

    // split-access helpers
    logic [1:0]  last_k;
    logic [1:0]  k_nxt;
    logic [31:0] byte_asm;
    logic [31:0] byte_ext;

    always_comb begin
        last_k   = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
        k_nxt    = k_q + 2'd1;
        // buffer including the byte arriving this cycle
        byte_asm = buf_q | ({24'd0, mem_Dout[7:0]} << {k_q, 3'b000});
        if (f3_q[1:0] == 2'b01)
            byte_ext = f3_q[2] ? {16'd0, byte_asm[15:0]}
                               : {{16{byte_asm[15]}}, byte_asm[15:0]};
        else
            byte_ext = byte_asm;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            st_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            k_q         <= 2'd0;
            buf_q       <= 32'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_fault  <= 1'b0;
            mem_addr    <= 32'd0;
            mem_Din     <= 32'd0;
            we_q        <= 2'b00;
            mem_RD_Type <= 3'b010;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        st_q    <= req_store;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        k_q     <= 2'd0;
                        buf_q   <= 32'd0;
                        if (req_fault) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_misal) begin
                            state       <= S_BYTE;
                            mem_addr    <= req_addr;
                            mem_Din     <= req_wdata;
                            we_q        <= req_store ? 2'b01 : 2'b00;
                            mem_RD_Type <= 3'b100;
                        end else begin
                            state       <= S_ACCESS;
                            mem_addr    <= req_addr;
                            mem_Din     <= req_wdata;
                            // WE code is size code + 1 for legal stores
                            we_q        <= req_store ? (req_funct3[1:0] + 2'd1) : 2'b00;
                            mem_RD_Type <= req_funct3;
                        end
                    end
                end
                S_ACCESS: begin
                    state      <= S_RESP;
                    we_q       <= 2'b00;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= st_q ? 32'd0 : mem_Dout;
                end
                S_BYTE: begin
                    if (!st_q)
                        buf_q <= byte_asm;
                    if (k_q == last_k) begin
                        state      <= S_RESP;
                        we_q       <= 2'b00;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= st_q ? 32'd0 : byte_ext;
                    end else begin
                        k_q      <= k_nxt;
                        mem_addr <= addr_q + {30'd0, k_nxt};
                        mem_Din  <= wdata_q >> {k_nxt, 3'b000};
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign mem_WR_Addr = mem_addr;
    assign mem_RD_Addr = mem_addr;
    // Rst blocks the write in the cycle it is asserted, so a reset during a
    // split store leaves the in-flight byte unwritten.
    assign mem_WE      = Rst ? 2'b00 : we_q;

endmodule
